// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: operation encodings,
// FSM state encoding, control-line bundle and the default counter width.
package datapath_sequencer_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_LOAD_IN  = 2'b00,
        OP_LOAD_REG = 2'b01,
        OP_SUB_ONCE = 2'b10,
        OP_SUB_LOOP = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RDREG = 3'd1,
        ST_WRITE = 3'd2,
        ST_LOOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // First state entered after a command is accepted in IDLE.
    function automatic state_e first_state(input op_e op);
        state_e st;
        case (op)
            OP_LOAD_REG: st = ST_RDREG;
            OP_SUB_LOOP: st = ST_LOOP;
            OP_LOAD_IN:  st = ST_WRITE;
            OP_SUB_ONCE: st = ST_WRITE;
            default:     st = ST_WRITE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command/status and datapath control bundle between the instruction
// decoder/datapath (master) and the sequencer (slave).
// Optional abort support is enabled with the DATAPATH_SEQ_ABORT_EN macro.
interface datapath_sequencer_if #(
    parameter int CNT_W = datapath_sequencer_pkg::CNT_W_DEF
);
    logic             start;
    logic [1:0]       op;
    logic             sub_borrow;
    logic             busy;
    logic             done;
    logic             saturated;
    logic [CNT_W-1:0] iter_count;
    logic             CTRL1;
    logic             CTRL2;
    logic             CTRL6;
    logic             CTRL7;
`ifdef DATAPATH_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output start, op, sub_borrow, abort,
        input  busy, done, saturated, iter_count, aborted,
        input  CTRL1, CTRL2, CTRL6, CTRL7
    );

    modport slave (
        input  start, op, sub_borrow, abort,
        output busy, done, saturated, iter_count, aborted,
        output CTRL1, CTRL2, CTRL6, CTRL7
    );
`else
    modport master (
        output start, op, sub_borrow,
        input  busy, done, saturated, iter_count,
        input  CTRL1, CTRL2, CTRL6, CTRL7
    );

    modport slave (
        input  start, op, sub_borrow,
        output busy, done, saturated, iter_count,
        output CTRL1, CTRL2, CTRL6, CTRL7
    );
`endif
endinterface

// File: rtl/datapath_seq_counter.sv
// Iteration counter: synchronous clear, load-one, saturating increment,
// and a flag that is high while the count equals MAX_ITER.
module datapath_seq_counter #(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(16'hFFFF)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_one_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max_s;

    assign at_max_s = (count_q == MAX_ITER);

    // Next count: clear wins over load-one, which wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_one_i) begin
            count_d = CNT_W'(1'b1);
        end else if (inc_i && !at_max_s) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = at_max_s;

endmodule

// File: rtl/datapath_sequencer.sv
// Datapath sequencer: accepts one command per handshake and drives the
// CTRL1/CTRL2/CTRL6/CTRL7 lines of the a0 datapath, including a
// repeated-subtract loop that stops on borrow or at MAX_ITER writes.
// Optional feature macro: DATAPATH_SEQ_ABORT_EN (abort input / aborted flag).
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(16'hFFFF)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    datapath_sequencer_if.slave   bus
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   sat_q, sat_d;

    logic   busy_s, done_s;
    logic   ctrl1_s, ctrl2_s, ctrl6_s, ctrl7_s;
    logic   cnt_clr_s, cnt_one_s, cnt_inc_s;
    logic   at_max_s;
    logic   abort_s;
    logic [CNT_W-1:0] count_s;

`ifdef DATAPATH_SEQ_ABORT_EN
    logic   aborted_q, aborted_d;
    assign abort_s     = bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign abort_s = 1'b0;
`endif

    datapath_seq_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_counter (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .clr_i      (cnt_clr_s),
        .load_one_i (cnt_one_s),
        .inc_i      (cnt_inc_s),
        .count_o    (count_s),
        .at_max_o   (at_max_s)
    );

    // Next-state, counter control and Moore-style datapath controls.
    // Only CTRL7 in LOOP looks at the live borrow (and abort) input.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sat_d     = sat_q;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        ctrl1_s   = 1'b0;
        ctrl2_s   = 1'b0;
        ctrl6_s   = 1'b0;
        ctrl7_s   = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_one_s = 1'b0;
        cnt_inc_s = 1'b0;
`ifdef DATAPATH_SEQ_ABORT_EN
        aborted_d = aborted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (bus.start) begin
                    op_d      = op_e'(bus.op);
                    sat_d     = 1'b0;
                    cnt_clr_s = 1'b1;
                    state_d   = first_state(op_e'(bus.op));
`ifdef DATAPATH_SEQ_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDREG: begin
                ctrl1_s = 1'b1;
                ctrl6_s = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ctrl7_s   = 1'b1;
                ctrl1_s   = (op_q == OP_LOAD_REG);
                ctrl2_s   = (op_q == OP_SUB_ONCE);
                cnt_one_s = 1'b1;
                state_d   = ST_DONE;
            end
            ST_LOOP: begin
                ctrl2_s = 1'b1;
                if (bus.sub_borrow || at_max_s || abort_s) begin
                    // Exit cycle performs no write.
                    sat_d   = at_max_s;
                    state_d = ST_DONE;
`ifdef DATAPATH_SEQ_ABORT_EN
                    aborted_d = abort_s;
`endif
                end else begin
                    ctrl7_s   = 1'b1;
                    cnt_inc_s = 1'b1;
                    state_d   = ST_LOOP;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched op and status flags; reset aborts any operation.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD_IN;
            sat_q     <= 1'b0;
`ifdef DATAPATH_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sat_q     <= sat_d;
`ifdef DATAPATH_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.saturated  = sat_q;
    assign bus.iter_count = count_s;
    assign bus.CTRL1      = ctrl1_s;
    assign bus.CTRL2      = ctrl2_s;
    assign bus.CTRL6      = ctrl6_s;
    assign bus.CTRL7      = ctrl7_s;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed, table-driven bench for datapath_sequencer with a small a0
// datapath model (mux_0, mux_1, subtractor, a0 register).
module tb_datapath_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    datapath_sequencer_if #(.CNT_W(16)) bus0 ();
    datapath_sequencer_if #(.CNT_W(16)) bus1 ();

    datapath_sequencer #(.CNT_W(16), .MAX_ITER(16'hFFFF)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus0)
    );

    datapath_sequencer #(.CNT_W(16), .MAX_ITER(16'd4)) dut_sat (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus1)
    );

    // a0 datapath model for the main instance; operand is register_value.
    logic [15:0] a0_q;
    logic [15:0] a0_in;
    logic [15:0] reg_val;
    logic [15:0] mux0_s, sub_s, mux1_s;
    assign mux0_s          = bus0.CTRL1 ? reg_val : a0_in;
    assign sub_s           = a0_q - reg_val;
    assign mux1_s          = bus0.CTRL2 ? sub_s : mux0_s;
    assign bus0.sub_borrow = (a0_q < reg_val);
    always @(posedge clk) if (bus0.CTRL7) a0_q <= mux1_s;

    // Saturation instance subtracts zero: never borrows.
    assign bus1.sub_borrow = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a0_in;
        logic [15:0] reg_val;
        logic [3:0]  exp_c1;     // {CTRL1,CTRL2,CTRL6,CTRL7} at T+1
        int          exp_writes;
        logic [15:0] exp_a0;
        logic [15:0] exp_iter;
        int          exp_done;   // cycle offset of done after accept edge
    } vec_t;

    vec_t vecs[10];

    // Issue one command on bus0 and watch it until done (bounded).
    task automatic run0(input logic [1:0] op_v, input int abort_k, input bit poke,
                        output logic [3:0] c1, output int writes, output int done_k);
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.op    = op_v;
        writes = 0;
        done_k = 0;
        c1     = 4'b0000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus0.start = poke && (k <= 2);
            if (poke) bus0.op = 2'b00;
`ifdef DATAPATH_SEQ_ABORT_EN
            bus0.abort = (k == abort_k);
`endif
            #1;
            if (k == 1) c1 = {bus0.CTRL1, bus0.CTRL2, bus0.CTRL6, bus0.CTRL7};
            if (bus0.CTRL7) writes++;
            if (bus0.done) begin
                done_k = k;
                break;
            end
        end
        bus0.start = 1'b0;
`ifdef DATAPATH_SEQ_ABORT_EN
        bus0.abort = 1'b0;
`endif
    endtask

    initial begin
        logic [3:0] c1;
        int         wr, dk;

        vecs[0] = '{2'b00, 16'h1234, 16'h0000, 4'b0001, 1, 16'h1234, 16'd1, 2};
        vecs[1] = '{2'b01, 16'h0000, 16'h00AB, 4'b1010, 1, 16'h00AB, 16'd1, 3};
        vecs[2] = '{2'b10, 16'h0000, 16'h0003, 4'b0101, 1, 16'h00A8, 16'd1, 2};
        vecs[3] = '{2'b00, 16'h0011, 16'h0005, 4'b0001, 1, 16'h0011, 16'd1, 2};
        vecs[4] = '{2'b11, 16'h0000, 16'h0005, 4'b0101, 3, 16'h0002, 16'd3, 5};
        vecs[5] = '{2'b00, 16'h0003, 16'h0005, 4'b0001, 1, 16'h0003, 16'd1, 2};
        vecs[6] = '{2'b11, 16'h0000, 16'h0005, 4'b0100, 0, 16'h0003, 16'd0, 2};
        vecs[7] = '{2'b00, 16'h000A, 16'h0005, 4'b0001, 1, 16'h000A, 16'd1, 2};
        vecs[8] = '{2'b11, 16'h0000, 16'h0005, 4'b0101, 2, 16'h0000, 16'd2, 4};
        vecs[9] = '{2'b10, 16'h0000, 16'h0005, 4'b0101, 1, 16'hFFFB, 16'd1, 2};

        // Reset held two cycles with start asserted.
        rst_n = 1'b0;
        bus0.start = 1'b1; bus0.op = 2'b00;
        bus1.start = 1'b1; bus1.op = 2'b00;
`ifdef DATAPATH_SEQ_ABORT_EN
        bus0.abort = 1'b0;
        bus1.abort = 1'b0;
`endif
        a0_in = 16'h0000; reg_val = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  32'(bus0.busy), 32'd0);
        chk("rst_done",  32'(bus0.done), 32'd0);
        chk("rst_ctrl",  32'({bus0.CTRL1, bus0.CTRL2, bus0.CTRL6, bus0.CTRL7}), 32'd0);
        chk("rst_iter",  32'(bus0.iter_count), 32'd0);
        chk("rst_sat",   32'(bus0.saturated), 32'd0);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b1;

        // Table-driven commands on the main instance.
        for (int i = 0; i < 10; i++) begin
            a0_in   = vecs[i].a0_in;
            reg_val = vecs[i].reg_val;
            run0(vecs[i].op, 0, 1'b0, c1, wr, dk);
            chk($sformatf("v%0d_ctrl_t1", i), 32'(c1), 32'(vecs[i].exp_c1));
            chk($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].exp_writes));
            chk($sformatf("v%0d_done_at", i), 32'(dk), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_a0", i), 32'(a0_q), 32'(vecs[i].exp_a0));
            chk($sformatf("v%0d_iter", i), 32'(bus0.iter_count), 32'(vecs[i].exp_iter));
            chk($sformatf("v%0d_sat", i), 32'(bus0.saturated), 32'd0);
            @(negedge clk); #1;
            chk($sformatf("v%0d_idle_busy", i), 32'(bus0.busy), 32'd0);
        end

        // start pulsed while busy must be ignored and not queued.
        a0_in = 16'h0077; reg_val = 16'h0055;
        run0(2'b01, 0, 1'b1, c1, wr, dk);
        chk("poke_done_at", 32'(dk), 32'd3);
        chk("poke_a0", 32'(a0_q), 32'h0055);
        @(negedge clk); #1;
        chk("poke_idle1", 32'(bus0.busy), 32'd0);
        @(negedge clk); #1;
        chk("poke_idle2", 32'(bus0.busy), 32'd0);

        // Reset in the middle of a long SUB_LOOP.
        a0_in = 16'd100; reg_val = 16'd1;
        run0(2'b00, 0, 1'b0, c1, wr, dk);
        @(negedge clk);
        bus0.start = 1'b1; bus0.op = 2'b11;
        repeat (3) begin
            @(negedge clk);
            bus0.start = 1'b0;
        end
        #1;
        chk("mid_loop_ctrl7", 32'(bus0.CTRL7), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_loop_ctrl7", 32'(bus0.CTRL7), 32'd0);
        chk("rst_loop_busy", 32'(bus0.busy), 32'd0);
        chk("rst_loop_iter", 32'(bus0.iter_count), 32'd0);
        chk("rst_loop_done", 32'(bus0.done), 32'd0);
        rst_n = 1'b1;
        a0_in = 16'h0042;
        run0(2'b00, 0, 1'b0, c1, wr, dk);
        chk("post_rst_done_at", 32'(dk), 32'd2);
        chk("post_rst_a0", 32'(a0_q), 32'h0042);

`ifdef DATAPATH_SEQ_ABORT_EN
        // Abort in the second loop cycle: one write, then DONE.
        a0_in = 16'd100; reg_val = 16'd1;
        run0(2'b00, 0, 1'b0, c1, wr, dk);
        run0(2'b11, 2, 1'b0, c1, wr, dk);
        chk("abort_writes", 32'(wr), 32'd1);
        chk("abort_done_at", 32'(dk), 32'd3);
        chk("abort_flag", 32'(bus0.aborted), 32'd1);
        chk("abort_iter", 32'(bus0.iter_count), 32'd1);
        chk("abort_a0", 32'(a0_q), 32'd99);
`endif

        // Saturation on the MAX_ITER=4 instance.
        @(negedge clk);
        bus1.start = 1'b1; bus1.op = 2'b11;
        wr = 0; dk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            #1;
            if (bus1.CTRL7) wr++;
            if (bus1.done) begin
                dk = k;
                break;
            end
        end
        chk("sat_writes", 32'(wr), 32'd4);
        chk("sat_done_at", 32'(dk), 32'd6);
        chk("sat_flag", 32'(bus1.saturated), 32'd1);
        chk("sat_iter", 32'(bus1.iter_count), 32'd4);
        @(negedge clk); #1;
        chk("sat_held", 32'(bus1.saturated), 32'd1);
        bus1.start = 1'b1; bus1.op = 2'b00;
        @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk); #1;
        chk("sat_cleared_done", 32'(bus1.done), 32'd1);
        chk("sat_cleared", 32'(bus1.saturated), 32'd0);
        chk("sat_load_iter", 32'(bus1.iter_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
